fpu_issue_ctrl: RTL

// Sequences multi-cycle FPU (D-class) instructions flagged by the control decoder (alu_fpu=1).

---
 rtl/fpu_issue_ctrl_if.sv | 27 ++
 rtl/fpu_issue_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// FPU-side handshake bundle: the issue channel (op offer/accept) and the result channel.
// The controller uses the master modport and the FPU (or its model) uses the slave modport.
interface fpu_issue_ctrl_if #(
    parameter int INSTR_WIDTH = 32
);
    logic                   fpu_req_valid;
    logic                   fpu_req_ready;
    logic [INSTR_WIDTH-1:0] fpu_op;
    logic                   fpu_resp_valid;
    logic                   fpu_resp_ready;

    modport master (
        output fpu_req_valid,
        output fpu_op,
        output fpu_resp_ready,
        input  fpu_req_ready,
        input  fpu_resp_valid
    );

    modport slave (
        input  fpu_req_valid,
        input  fpu_op,
        input  fpu_resp_ready,
        output fpu_req_ready,
        output fpu_resp_valid
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for multi-cycle FPU ops: one op in flight, decode hazard stalls,
// timeout abort, and arbitration of the shared register-file write port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no FPU op in flight; decode may hand over a new FPU op
// REQ    | op captured and offered to the FPU, waiting for acceptance
// WAIT   | op accepted, waiting for the result; writeback on response
module fpu_issue_ctrl #(
    parameter int INSTR_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic                      id_alu_fpu,
    input  logic [INSTR_WIDTH-1:0]    id_instr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      alu_wb_valid,
    fpu_issue_ctrl_if.master          fpu,
    output logic                      stall,
    output logic                      wb_sel,
    output logic                      wb_en,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      busy,
    output logic                      timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [REG_ADDR_WIDTH-1:0] pend_rd;
    logic [INSTR_WIDTH-1:0]    op_q;
    logic [CNT_WIDTH-1:0]      cnt;
    logic                      err_q;

    logic                      accept;
    logic                      resp_fire;
    logic                      abort;
    logic                      hazard;
    logic                      collision;

    logic                      req_valid_c;
    logic                      resp_ready_c;
    logic                      busy_c;
    logic                      stall_c;
    logic                      wb_sel_c;
    logic                      wb_en_c;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_c;

    assign resp_fire = (state == S_WAIT) && fpu.fpu_resp_valid;
    // A result arriving on the last allowed cycle still wins over the abort.
    assign abort     = (state != S_IDLE) && (cnt == CNT_LAST) && !resp_fire;
    // Source compares are deliberately conservative: rs1/rs2 are checked even if unused.
    assign hazard    = (pend_rd != '0) &&
                       ((id_rs1 == pend_rd) || (id_rs2 == pend_rd) || (id_rd == pend_rd));
    assign collision = resp_fire && alu_wb_valid;
    assign accept    = (state == S_IDLE) && id_valid && id_alu_fpu && !stall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (fpu.fpu_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_fire || abort) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_c       = (state != S_IDLE);
        req_valid_c  = (state == S_REQ);
        resp_ready_c = (state == S_WAIT);
        wb_sel_c     = resp_fire;
        wb_en_c      = resp_fire && (pend_rd != '0);
        wb_rd_c      = '0;
        if (resp_fire) begin
            wb_rd_c = pend_rd;
        end
        stall_c      = collision || (busy_c && id_valid && (id_alu_fpu || hazard));
    end

    // Op capture, destination tracking, timeout counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            pend_rd <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= id_instr;
                pend_rd <= id_rd;
                cnt     <= '0;
            end else if (state != S_IDLE) begin
                cnt <= cnt + 1'b1;
            end
            if (abort) begin
                pend_rd <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign fpu.fpu_req_valid  = req_valid_c;
    assign fpu.fpu_resp_ready = resp_ready_c;
    assign fpu.fpu_op         = op_q;
    assign stall              = stall_c;
    assign wb_sel             = wb_sel_c;
    assign wb_en              = wb_en_c;
    assign wb_rd              = wb_rd_c;
    assign busy               = busy_c;
    assign timeout_err        = err_q;

endmodule
